// File: rtl/key_event_gen.sv
// key_event_gen
// Turns the debounced key level into press / release / auto-repeat events.
// Each event is a one-cycle pulse. It is also latched into a one-entry event
// register with a valid/ack handshake, so a slow consumer does not lose it.
// A sticky overflow flag records any unacknowledged event that was overwritten.

module key_event_gen #(
  parameter bit          pActiveLow    = 1'b1,
  parameter int unsigned pHoldCycles   = 32'd50000000,
  parameter int unsigned pRepeatCycles = 32'd10000000
) (
  input  logic       iwClk,
  input  logic       iwnRst,
  input  logic       iwKeyIn,
  input  logic       iwAck,
  output logic       orPress,
  output logic       orRelease,
  output logic       orRepeat,
  output logic       orHeld,
  output logic       orEventValid,
  output logic [1:0] orEventKind,
  output logic       orOverflow
);

  typedef enum logic [1:0] {
    sIdle   = 2'd0,
    sHold   = 2'd1,
    sRepeat = 2'd2
  } state_t;

  localparam logic [1:0] cKindNone    = 2'b00;
  localparam logic [1:0] cKindPress   = 2'b01;
  localparam logic [1:0] cKindRelease = 2'b10;
  localparam logic [1:0] cKindRepeat  = 2'b11;

  // Terminal counts. They are guarded so that a zero parameter cannot wrap to all-ones.
  localparam logic [31:0] cHoldLast   = (pHoldCycles   == 0) ? 32'd0 : 32'(pHoldCycles - 1);
  localparam logic [31:0] cRepeatLast = (pRepeatCycles == 0) ? 32'd0 : 32'(pRepeatCycles - 1);
  localparam bit          cRepeatEn   = (pHoldCycles != 0);

  state_t      rState;
  logic [31:0] rCount;
  logic        wActive;
  logic [1:0]  wEvent;

  assign wActive = iwKeyIn ^ pActiveLow;

  // Decide which event, if any, the coming edge produces. A release takes priority over a terminal count.
  always_comb begin
    wEvent = cKindNone;
    case (rState)
      sIdle: begin
        if (wActive) wEvent = cKindPress;
      end
      sHold: begin
        if (!wActive)                                  wEvent = cKindRelease;
        else if (cRepeatEn && (rCount == cHoldLast))   wEvent = cKindRepeat;
      end
      sRepeat: begin
        if (!wActive)                    wEvent = cKindRelease;
        else if (rCount == cRepeatLast)  wEvent = cKindRepeat;
      end
      default: wEvent = cKindNone;
    endcase
  end

  // Key state machine, hold/repeat counter and the one-cycle event pulses.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      rState    <= sIdle;
      rCount    <= 32'd0;
      orPress   <= 1'b0;
      orRelease <= 1'b0;
      orRepeat  <= 1'b0;
      orHeld    <= 1'b0;
    end else begin
      orPress   <= (wEvent == cKindPress);
      orRelease <= (wEvent == cKindRelease);
      orRepeat  <= (wEvent == cKindRepeat);
      case (rState)
        sIdle: begin
          if (wActive) begin
            rState <= sHold;
            rCount <= 32'd0;
            orHeld <= 1'b1;
          end
        end
        sHold: begin
          if (!wActive) begin
            rState <= sIdle;
            rCount <= 32'd0;
            orHeld <= 1'b0;
          end else if (cRepeatEn) begin
            if (rCount == cHoldLast) begin
              rState <= sRepeat;
              rCount <= 32'd0;
            end else begin
              rCount <= rCount + 32'd1;
            end
          end
        end
        sRepeat: begin
          if (!wActive) begin
            rState <= sIdle;
            rCount <= 32'd0;
            orHeld <= 1'b0;
          end else if (rCount == cRepeatLast) begin
            rCount <= 32'd0;
          end else begin
            rCount <= rCount + 32'd1;
          end
        end
        default: begin
          rState <= sIdle;
          rCount <= 32'd0;
          orHeld <= 1'b0;
        end
      endcase
    end
  end

  // One-entry event register. A new event wins over an ack. An overwrite without an ack is flagged as overflow.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      orEventValid <= 1'b0;
      orEventKind  <= cKindNone;
      orOverflow   <= 1'b0;
    end else if (wEvent != cKindNone) begin
      if (orEventValid && !iwAck) orOverflow <= 1'b1;
      orEventValid <= 1'b1;
      orEventKind  <= wEvent;
    end else if (iwAck) begin
      orEventValid <= 1'b0;
      orEventKind  <= cKindNone;
    end
  end

endmodule
